// File: rtl/shift_reg_pkg.sv
// Mode encoding shared by the product register and the multiplier controller.
package shift_reg_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_SHL  = 2'b11;

   // True for either shift encoding; both share the mode[1] bit.
   function automatic logic is_shift(input logic [1:0] mode);
      return mode[1];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a registered at-maximum flag.
module sat_counter #(
   parameter int unsigned MAX = 8,
   parameter int unsigned W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         atMax
);

   logic [W-1:0] count_nxt;

   // Next count: clear wins, increments stop at MAX.
   always_comb begin
      count_nxt = count;
      if (clear) begin
         count_nxt = '0;
      end else if (inc && (count < W'(MAX))) begin
         count_nxt = count + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         atMax <= 1'b0;
      end else begin
         count <= count_nxt;
         atMax <= (count_nxt == W'(MAX));
      end
   end

endmodule

// File: rtl/shift_reg_ctr.sv
// Parametrised product register: load, hold, left/right shift with serial
// in/out, plus a saturating shift counter whose done flag marks WIDTH shifts.
module shift_reg_ctr
   import shift_reg_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             serialIn,
   input  logic [WIDTH-1:0] inData,
   output logic [WIDTH-1:0] outData,
   output logic             serialOut,
   output logic [CNT_W-1:0] shiftCount,
   output logic             done
);

   always_ff @(posedge clk) begin
      if (reset) begin
         outData   <= '0;
         serialOut <= 1'b0;
      end else begin
         case (mode)
            MODE_HOLD: begin
               outData   <= outData;
               serialOut <= serialOut;
            end
            MODE_LOAD: begin
               outData   <= inData;
               serialOut <= serialOut;
            end
            MODE_SHR: begin
               outData   <= {serialIn, outData[WIDTH-1:1]};
               serialOut <= outData[0];
            end
            MODE_SHL: begin
               outData   <= {outData[WIDTH-2:0], serialIn};
               serialOut <= outData[WIDTH-1];
            end
         endcase
      end
   end

   // Direction is not tracked: any shift advances the same counter.
   sat_counter #(
      .MAX (WIDTH),
      .W   (CNT_W)
   ) u_shift_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (mode == MODE_LOAD),
      .inc   (is_shift(mode)),
      .count (shiftCount),
      .atMax (done)
   );

endmodule

// File: tb/tb_shift_reg_ctr.sv
// Bench for shift_reg_ctr at WIDTH 8, 2 and 33 driven by shared stimulus,
// checked every cycle against a behavioural model plus literal expectations.
module tb_shift_reg_ctr;
   import shift_reg_pkg::*;

   localparam int NI = 3;
   localparam int WS [NI] = '{8, 2, 33};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  mode = MODE_HOLD;
   logic        sin = 1'b0;
   logic [63:0] din = '0;

   logic [7:0]  od8;  logic so8;  logic [3:0] sc8;  logic dn8;
   logic [1:0]  od2;  logic so2;  logic [1:0] sc2;  logic dn2;
   logic [32:0] od33; logic so33; logic [5:0] sc33; logic dn33;

   int total = 0;
   int bad = 0;
   bit started = 1'b0;

   logic [63:0] mval [NI];
   logic        mso  [NI];
   int          mcnt [NI];

   always #5 clk = ~clk;

   shift_reg_ctr #(.WIDTH(8)) u_w8 (
      .clk(clk), .reset(reset), .mode(mode), .serialIn(sin), .inData(din[7:0]),
      .outData(od8), .serialOut(so8), .shiftCount(sc8), .done(dn8));
   shift_reg_ctr #(.WIDTH(2)) u_w2 (
      .clk(clk), .reset(reset), .mode(mode), .serialIn(sin), .inData(din[1:0]),
      .outData(od2), .serialOut(so2), .shiftCount(sc2), .done(dn2));
   shift_reg_ctr #(.WIDTH(33)) u_w33 (
      .clk(clk), .reset(reset), .mode(mode), .serialIn(sin), .inData(din[32:0]),
      .outData(od33), .serialOut(so33), .shiftCount(sc33), .done(dn33));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: register as an integer value, counter as min(shifts, W).
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int w;
         logic [63:0] mask;
         w = WS[i];
         mask = (64'd1 << w) - 64'd1;
         if (reset) begin
            mval[i] = '0;
            mso[i]  = 1'b0;
            mcnt[i] = 0;
         end else if (mode == MODE_LOAD) begin
            mval[i] = din & mask;
            mcnt[i] = 0;
         end else if (mode == MODE_SHR || mode == MODE_SHL) begin
            if (mode == MODE_SHR) begin
               mso[i]  = mval[i][0];
               mval[i] = (mval[i] >> 1) | (64'(sin) << (w - 1));
            end else begin
               mso[i]  = mval[i][w-1];
               mval[i] = ((mval[i] << 1) | 64'(sin)) & mask;
            end
            mcnt[i] = (mcnt[i] < w) ? mcnt[i] + 1 : w;
         end
      end
   end

   task automatic cmp_inst(input int i, input logic [63:0] od, input logic [63:0] sc,
                           input logic so, input logic dn);
      chk($sformatf("w%0d_outData", WS[i]), od, mval[i]);
      chk($sformatf("w%0d_serialOut", WS[i]), 64'(so), 64'(mso[i]));
      chk($sformatf("w%0d_shiftCount", WS[i]), sc, 64'(mcnt[i]));
      chk($sformatf("w%0d_done", WS[i]), 64'(dn), 64'(mcnt[i] == WS[i]));
   endtask

   always @(negedge clk) begin
      if (started) begin
         cmp_inst(0, 64'(od8),  64'(sc8),  so8,  dn8);
         cmp_inst(1, 64'(od2),  64'(sc2),  so2,  dn2);
         cmp_inst(2, 64'(od33), 64'(sc33), so33, dn33);
      end
   end

   task automatic step(input logic r, input logic [1:0] m, input logic s, input logic [63:0] d);
      reset = r;
      mode  = m;
      sin   = s;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] shr_so;
      shr_so = 8'b1010_0101;

      // Reset beats LOAD
      step(1'b1, MODE_LOAD, 1'b0, 64'hFF);
      started = 1'b1;
      chk("rst_outData", 64'(od8), 64'h00);
      chk("rst_serialOut", 64'(so8), 64'h0);
      chk("rst_shiftCount", 64'(sc8), 64'h0);
      chk("rst_done", 64'(dn8), 64'h0);

      // Load and hold
      step(1'b0, MODE_LOAD, 1'b0, 64'hA5);
      chk("load_outData", 64'(od8), 64'hA5);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, MODE_HOLD, 1'b1, 64'h00);
         chk("hold_outData", 64'(od8), 64'hA5);
         chk("hold_shiftCount", 64'(sc8), 64'h0);
      end

      // SHR to done; serialOut leaves A5 LSB first
      step(1'b0, MODE_LOAD, 1'b0, 64'hA5);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, MODE_SHR, 1'b1, 64'h00);
         chk("shr_serialOut", 64'(so8), 64'(shr_so[k]));
         chk("shr_shiftCount", 64'(sc8), 64'(k + 1));
         chk("shr_done", 64'(dn8), 64'(k == 7));
         if (k < 2) chk("w2_shr_done", 64'(dn2), 64'(k == 1));
      end
      chk("shr_final_outData", 64'(od8), 64'hFF);
      chk("w2_sat_count", 64'(sc2), 64'd2);

      // Full WIDTH=33 sequence, then over-shift
      step(1'b0, MODE_LOAD, 1'b0, 64'h1_2345_6789);
      for (int k = 0; k < 35; k++) begin
         step(1'b0, MODE_SHR, 1'b0, 64'h0);
         if (k == 31) chk("w33_done_early", 64'(dn33), 64'h0);
         if (k >= 32) chk("w33_done", 64'(dn33), 64'h1);
      end
      chk("w33_sat_count", 64'(sc33), 64'd33);
      chk("w33_outData", 64'(od33), 64'h0);

      // SHL and saturation
      step(1'b0, MODE_LOAD, 1'b0, 64'h81);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, MODE_SHL, 1'b0, 64'h0);
         if (k == 0) chk("shl_first_serialOut", 64'(so8), 64'h1);
         if (k == 7) chk("shl_outData_zero", 64'(od8), 64'h00);
         if (k >= 7) begin
            chk("shl_sat_count", 64'(sc8), 64'd8);
            chk("shl_sat_done", 64'(dn8), 64'h1);
         end
      end

      // Reset mid-sequence aborts, even with a shift mode applied
      step(1'b0, MODE_LOAD, 1'b0, 64'h3C);
      for (int k = 0; k < 4; k++) step(1'b0, MODE_SHR, 1'b1, 64'h0);
      step(1'b1, MODE_SHL, 1'b1, 64'h0);
      chk("abort_outData", 64'(od8), 64'h00);
      chk("abort_serialOut", 64'(so8), 64'h0);
      chk("abort_shiftCount", 64'(sc8), 64'h0);

      // LOAD after partial shifting restarts the counter
      step(1'b0, MODE_LOAD, 1'b0, 64'h3C);
      for (int k = 0; k < 5; k++) step(1'b0, MODE_SHL, 1'b0, 64'h0);
      step(1'b0, MODE_LOAD, 1'b0, 64'h0F);
      chk("reload_outData", 64'(od8), 64'h0F);
      chk("reload_shiftCount", 64'(sc8), 64'h0);
      chk("reload_done", 64'(dn8), 64'h0);

      // Mixed directions share one counter
      for (int k = 0; k < 4; k++) step(1'b0, MODE_SHR, 1'b0, 64'h0);
      for (int k = 0; k < 4; k++) step(1'b0, MODE_SHL, 1'b0, 64'h0);
      chk("mixed_done", 64'(dn8), 64'h1);
      chk("mixed_outData", 64'(od8), 64'h00);

      // Random mode/data traffic checked by the model only
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
              {32'($urandom), 32'($urandom)});
      end

      step(1'b0, MODE_HOLD, 1'b0, 64'h0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
